register_delay_chain: RTL and testbench



---
 rtl/register_delay_chain_pkg.sv | 30 +++
 rtl/register_delay_chain_stage.sv | 24 ++
 rtl/register_delay_chain.sv | 73 +++++++
 tb/tb_register_delay_chain.sv | 129 ++++++++++++
 4 files changed

// File: rtl/register_delay_chain_pkg.sv
// Shared constants, types and the thermometer-mask helper for the
// programmable-length register delay chain.
package register_delay_pkg;

  // Default chain geometry
  localparam int DLY_STAGES = 8;
  localparam int DLY_WIDTH  = 7;
  localparam int DLY_SEL_W  = $clog2(DLY_STAGES);

  // Upper bound on chain length the mask helper can describe
  localparam int DLY_MAX_STAGES = 64;
  localparam int DLY_MAX_SEL_W  = $clog2(DLY_MAX_STAGES);

  typedef logic [DLY_WIDTH-1:0] dly_data_t;
  typedef logic [DLY_SEL_W-1:0] dly_sel_t;

  // Thermometer mask: bit i set iff i <= sel (unsigned compare).
  // Callers narrow the result to their own stage count.
  function automatic logic [DLY_MAX_STAGES-1:0] therm_mask(
    input logic [DLY_MAX_SEL_W-1:0] sel
  );
    logic [DLY_MAX_STAGES-1:0] mask;
    mask = '0;
    for (int i = 0; i < DLY_MAX_STAGES; i++) begin
      mask[i] = (DLY_MAX_SEL_W'(i) <= sel);
    end
    return mask;
  endfunction

endpackage

// File: rtl/register_delay_chain_stage.sv
// One D-bit delay stage: synchronous active-low clear, load when enabled,
// otherwise hold.
import register_delay_pkg::*;

module register_delay_stage #(
  parameter int D = DLY_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [D-1:0] d,
  output logic [D-1:0] q
);

  // Stage register: clear on reset, load when active, else freeze
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_delay_chain.sv
// Programmable-length delay line of A stages of D bits.
// sel_reg sets the last active stage, sel_mux picks the stage driven to out,
// reg_mc publishes the active-stage mask one cycle after sel_reg.
// Optional build macro REGISTER_DELAY_OUT_REG_EN registers out (one extra
// cycle of latency, reset value 0); otherwise out is a plain mux.
import register_delay_pkg::*;

module register_delay_chain #(
  parameter  int A = DLY_STAGES,
  parameter  int D = DLY_WIDTH,
  localparam int S = $clog2(A)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [D-1:0] data,
  input  logic [S-1:0] sel_reg,
  input  logic [S-1:0] sel_mux,
  output logic [D-1:0] out,
  output logic [A-1:0] reg_mc
);

  logic [A-1:0] en;
  logic [D-1:0] stage [A];

  // Stages at or below sel_reg shift; the rest hold their contents.
  // A is limited to DLY_MAX_STAGES by the helper's width.
  assign en = A'(therm_mask(DLY_MAX_SEL_W'(sel_reg)));

  // Shift chain: stage 0 takes data, stage i takes stage i-1
  for (genvar gi = 0; gi < A; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      register_delay_stage #(.D(D)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en[gi]),
        .d   (data),
        .q   (stage[gi])
      );
    end else begin : g_body
      register_delay_stage #(.D(D)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en[gi]),
        .d   (stage[gi-1]),
        .q   (stage[gi])
      );
    end
  end

  // Active-stage mask, published one cycle behind sel_reg
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_mc <= '0;
    end else begin
      reg_mc <= en;
    end
  end

`ifdef REGISTER_DELAY_OUT_REG_EN
  // Registered tap: adds one cycle to both data and sel_mux paths
  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= '0;
    end else begin
      out <= stage[sel_mux];
    end
  end
`else
  // Tap mux: A is a power of two so every sel_mux value is a valid stage
  assign out = stage[sel_mux];
`endif

endmodule

// File: tb/tb_register_delay_chain.sv
// Directed bench for register_delay_chain (default A=8, D=7).
module tb_register_delay_chain;

`ifdef REGISTER_DELAY_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [6:0] data;
  logic [2:0] sel_reg;
  logic [2:0] sel_mux;
  logic [6:0] out;
  logic [7:0] reg_mc;

  int n_checks;
  int n_fail;
  int n;
  int e;

  register_delay_chain dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .sel_reg (sel_reg),
    .sel_mux (sel_mux),
    .out     (out),
    .reg_mc  (reg_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected tap value when data value k was presented before edge k
  function automatic logic [7:0] stream_exp(input int edge_no, input int tap);
    int v;
    v = edge_no - tap - LAT + 1;
    return (v > 0) ? 8'(v & 8'h7F) : 8'h00;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held for three edges
    rst = 1'b0; data = 7'h55; sel_reg = 3'd7; sel_mux = 3'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_out", {1'b0, out}, 8'h00);
      check("reset_mc", reg_mc, 8'h00);
    end

    // Full chain, tap 7: data n presented before edge n
    rst = 1'b1; sel_mux = 3'd7;
    for (n = 1; n <= 12; n++) begin
      data = 7'(n);
      tick();
      if (n == 1) check("full_mc_lag", reg_mc, 8'hFF);
      check("full_out", {1'b0, out}, stream_exp(n, 7));
    end

    // Tap sweep with mux changes taking effect at once
    for (int m = 0; m < 8; m++) begin
      data = 7'(n);
      sel_mux = 3'(m);
      tick();
      check("tap_sweep", {1'b0, out}, stream_exp(n, m));
      n++;
    end

    // Shortened chain freezes stage 5 holding 2A
    data = 7'h2A;
    tick();
    for (int i = 0; i < 5; i++) begin
      data = 7'(8'h10 + i);
      tick();
    end
    check("pre_short_mc", reg_mc, 8'hFF);
    sel_reg = 3'd2; sel_mux = 3'd5; data = 7'h15;
    tick();
    check("short_mc", reg_mc, 8'h07);
    check("short_out0", {1'b0, out}, 8'h2A);
    for (int i = 0; i < 3; i++) begin
      data = 7'(8'h60 + i);
      tick();
      check("short_hold", {1'b0, out}, 8'h2A);
    end

    // Mid-stream reset pulse
    sel_reg = 3'd7; sel_mux = 3'd3;
    for (int i = 0; i < 4; i++) begin
      data = 7'(8'h40 + i);
      tick();
    end
    rst = 1'b0; data = 7'h7F;
    tick();
    check("mid_rst_out", {1'b0, out}, 8'h00);
    check("mid_rst_mc", reg_mc, 8'h00);
    rst = 1'b1;
    data = 7'h33; tick();
    check("post_rst_mc", reg_mc, 8'hFF);
    data = 7'h34; tick();
    data = 7'h35; tick();
    check("post_rst_e3", {1'b0, out}, 8'h00);
    data = 7'h36; tick();
    check("post_rst_e4", {1'b0, out}, (LAT == 1) ? 8'h33 : 8'h00);
    data = 7'h37; tick();
    check("post_rst_e5", {1'b0, out}, (LAT == 1) ? 8'h34 : 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
